// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file responder with independent write and read FSMs.
// Optional AxPROT secure-register rejection is compiled in with AXIL_REG_SLAVE_PROT_CHECK_EN.
`ifndef RESP_OKAY
`define RESP_OKAY 2'b00
`endif
`ifndef RESP_SLVERR
`define RESP_SLVERR 2'b10
`endif

module axil_reg_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter logic [DEPTH-1:0] SECURE_MASK = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic [2:0]                    AWPROT,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic [2:0]                    ARPROT,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [DEPTH*DATA_WIDTH-1:0]   REGS_OUT
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic                  wrdy_q, wrdy_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic [IDX_W-1:0] widx, ridx;
  logic             w_in_range, r_in_range, w_deny, r_deny;

  // Full-width compare so out-of-range addresses never alias onto a register.
  assign widx       = AWADDR[IDX_W-1:0];
  assign ridx       = ARADDR[IDX_W-1:0];
  assign w_in_range = ({1'b0, AWADDR} < DEPTH_A);
  assign r_in_range = ({1'b0, ARADDR} < DEPTH_A);

`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
  assign w_deny = AWPROT[1] & SECURE_MASK[widx];
  assign r_deny = ARPROT[1] & SECURE_MASK[ridx];
  logic unused_prot;
  assign unused_prot = ^{AWPROT[2], AWPROT[0], ARPROT[2], ARPROT[0]};
`else
  assign w_deny = 1'b0;
  assign r_deny = 1'b0;
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT, SECURE_MASK};
`endif

  always_comb begin
    wstate_d = wstate_q;
    wrdy_d   = 1'b0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (AWVALID && WVALID) begin
          wrdy_d   = 1'b1;
          wstate_d = W_ACK;
        end
      end
      W_ACK: begin
        bvalid_d = 1'b1;
        wstate_d = W_RESP;
        if (w_in_range && !w_deny) begin
          bresp_d = `RESP_OKAY;
          for (int b = 0; b < STRB_W; b++) begin
            if (WSTRB[b]) regs_d[widx][b*8 +: 8] = WDATA[b*8 +: 8];
          end
        end else begin
          bresp_d = `RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge write is not visible to the read.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (ARVALID) begin
          arready_d = 1'b1;
          rstate_d  = R_ACK;
        end
      end
      R_ACK: begin
        rvalid_d = 1'b1;
        rstate_d = R_DATA;
        if (r_in_range && !r_deny) begin
          rdata_d = regs_q[ridx];
          rresp_d = `RESP_OKAY;
        end else begin
          rdata_d = '0;
          rresp_d = `RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wrdy_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= `RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= `RESP_OKAY;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wrdy_q    <= wrdy_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign AWREADY = wrdy_q;
  assign WREADY  = wrdy_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs_out
    assign REGS_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed AXI4-Lite transactions plus a
// register-file model checked against B/R responses and REGS_OUT every cycle.
`timescale 1ns/1ps
`ifndef RESP_OKAY
`define RESP_OKAY 2'b00
`endif
`ifndef RESP_SLVERR
`define RESP_SLVERR 2'b10
`endif

module tb_axil_reg_slave;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam logic [DEPTH-1:0] SMASK = 8'h01;
`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [AW-1:0]   AWADDR = '0;
  logic [2:0]      AWPROT = '0;
  logic            AWVALID = 1'b0;
  logic            AWREADY;
  logic [DW-1:0]   WDATA = '0;
  logic [3:0]      WSTRB = '0;
  logic            WVALID = 1'b0;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY = 1'b0;
  logic [AW-1:0]   ARADDR = '0;
  logic [2:0]      ARPROT = '0;
  logic            ARVALID = 1'b0;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY = 1'b0;
  logic [DEPTH*DW-1:0] REGS_OUT;

  axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SECURE_MASK(SMASK)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REGS_OUT(REGS_OUT)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] strb; logic [2:0] prot; } wtxn_t;
  typedef struct { logic [AW-1:0] addr; logic [2:0] prot; } rtxn_t;

  logic [DW-1:0] m_regs [DEPTH];
  wtxn_t wq[$];
  rtxn_t rq[$];
  wtxn_t cur_w;
  rtxn_t cur_r;
  logic [1:0]    exp_bresp = `RESP_OKAY;
  logic [1:0]    exp_rresp = `RESP_OKAY;
  logic [DW-1:0] exp_rdata = '0;
  logic          b_prev = 1'b0;
  logic          r_prev = 1'b0;

  function automatic bit acc_ok(input logic [AW-1:0] a, input logic [2:0] p);
    if (int'(a) >= DEPTH) return 1'b0;
    if (PROT_EN && p[1] && SMASK[int'(a)]) return 1'b0;
    return 1'b1;
  endfunction

  // Reads that start responding in the same cycle as a write see the old contents.
  always @(negedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      wq.delete();
      rq.delete();
      b_prev = 1'b0;
      r_prev = 1'b0;
    end else begin
      if (RVALID && !r_prev) begin
        if (rq.size() == 0) begin
          check("r_orphan", 1, 0);
        end else begin
          cur_r = rq.pop_front();
          if (acc_ok(cur_r.addr, cur_r.prot)) begin
            exp_rdata = m_regs[int'(cur_r.addr)];
            exp_rresp = `RESP_OKAY;
          end else begin
            exp_rdata = '0;
            exp_rresp = `RESP_SLVERR;
          end
        end
      end
      if (RVALID) begin
        check("m_rdata", RDATA, exp_rdata);
        check("m_rresp", RRESP, exp_rresp);
      end
      if (BVALID && !b_prev) begin
        if (wq.size() == 0) begin
          check("b_orphan", 1, 0);
        end else begin
          cur_w = wq.pop_front();
          if (acc_ok(cur_w.addr, cur_w.prot)) begin
            exp_bresp = `RESP_OKAY;
            for (int b = 0; b < 4; b++)
              if (cur_w.strb[b]) m_regs[int'(cur_w.addr)][b*8 +: 8] = cur_w.data[b*8 +: 8];
          end else begin
            exp_bresp = `RESP_SLVERR;
          end
        end
      end
      if (BVALID) check("m_bresp", BRESP, exp_bresp);
      for (int i = 0; i < DEPTH; i++) check("m_regs_out", REGS_OUT[i*DW +: DW], m_regs[i]);
      b_prev = BVALID;
      r_prev = RVALID;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s, input logic [2:0] p);
    wtxn_t t;
    @(posedge ACLK); #1;
    AWADDR = a; WDATA = d; WSTRB = s; AWPROT = p;
    AWVALID = 1'b1; WVALID = 1'b1;
    t.addr = a; t.data = d; t.strb = s; t.prot = p;
    wq.push_back(t);
  endtask

  task automatic wait_accept();
    @(posedge ACLK); #1;
    check("aw_w_ready", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bvalid_latency", BVALID, 1'b1);
    check("ready_drop", {AWREADY, WREADY}, 2'b00);
  endtask

  task automatic complete_b(input int hold, output logic [1:0] resp);
    resp = BRESP;
    repeat (hold) begin
      @(posedge ACLK); #1;
      check("b_hold", {BVALID, BRESP}, {1'b1, resp});
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("b_done", BVALID, 1'b0);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input logic [2:0] p, output logic [1:0] resp);
    start_write(a, d, s, p);
    wait_accept();
    complete_b(0, resp);
  endtask

  task automatic start_read(input logic [AW-1:0] a, input logic [2:0] p);
    rtxn_t t;
    @(posedge ACLK); #1;
    ARADDR = a; ARPROT = p; ARVALID = 1'b1;
    t.addr = a; t.prot = p;
    rq.push_back(t);
  endtask

  task automatic read_accept();
    @(posedge ACLK); #1;
    check("arready", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("rvalid_latency", RVALID, 1'b1);
    check("arready_drop", ARREADY, 1'b0);
  endtask

  task automatic complete_r(input int hold, output logic [DW-1:0] d, output logic [1:0] resp);
    d = RDATA;
    resp = RRESP;
    repeat (hold) begin
      @(posedge ACLK); #1;
      check("r_hold", {RVALID, RRESP, RDATA}, {1'b1, resp, d});
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    check("r_done", RVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [2:0] p,
                          output logic [DW-1:0] d, output logic [1:0] resp);
    start_read(a, p);
    read_accept();
    complete_r(0, d, resp);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("rst_valid", {BVALID, RVALID}, 2'b00);
    check("rst_resp", {BRESP, RRESP}, {`RESP_OKAY, `RESP_OKAY});
    check("rst_rdata", RDATA, 0);
    check("rst_regs", (REGS_OUT == '0), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [1:0]       br, rr;
    logic [DW-1:0]    rd;
    logic [DW-1:0]    exp;
    logic [DEPTH*DW-1:0] snap;

    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    check_reset_outputs();

    // Fill every register, then read each back.
    for (int i = 0; i < DEPTH; i++) begin
      axi_write(AW'(i), DW'(32'h1F + i), 4'hF, 3'b010, br);
      check("fill_bresp", br, (PROT_EN && i == 0) ? `RESP_SLVERR : `RESP_OKAY);
    end
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(AW'(i), 3'b010, rd, rr);
      exp = (PROT_EN && i == 0) ? 32'h0 : DW'(32'h1F + i);
      check("fill_rdata", rd, exp);
      check("fill_rresp", rr, (PROT_EN && i == 0) ? `RESP_SLVERR : `RESP_OKAY);
    end

    // Byte-strobe merge.
    axi_write(8'd3, 32'hAABBCCDD, 4'hF, 3'b000, br);
    axi_write(8'd3, 32'h11223344, 4'b0101, 3'b000, br);
    check("strb_bresp", br, `RESP_OKAY);
    axi_read(8'd3, 3'b000, rd, rr);
    check("strb_rdata", rd, 32'hAA22CC44);
    check("strb_regs_out", REGS_OUT[127:96], 32'hAA22CC44);

    // Out-of-range accesses, no aliasing.
    snap = REGS_OUT;
    axi_write(8'd8, 32'hDEADBEEF, 4'hF, 3'b000, br);
    check("oor_bresp", br, `RESP_SLVERR);
    check("oor_regs_same", (REGS_OUT == snap), 1'b1);
    axi_read(8'd255, 3'b000, rd, rr);
    check("oor_rresp", rr, `RESP_SLVERR);
    check("oor_rdata", rd, 0);

    // Back-pressure on B with a second write already waiting.
    start_write(8'd4, 32'h0000_0444, 4'hF, 3'b000);
    wait_accept();
    br = BRESP;
    start_write(8'd5, 32'h0000_0555, 4'hF, 3'b000);
    repeat (4) begin
      @(posedge ACLK); #1;
      check("bp_hold", {BVALID, BRESP}, {1'b1, br});
      check("bp_no_ready", {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("bp_b_done", BVALID, 1'b0);
    check("bp_still_blocked", {AWREADY, WREADY}, 2'b00);
    wait_accept();
    complete_b(0, br);
    check("bp_second_bresp", br, `RESP_OKAY);
    check("bp_second_reg", REGS_OUT[5*DW +: DW], 32'h0000_0555);

    // BREADY/RREADY already high before the response.
    BREADY = 1'b1;
    start_write(8'd6, 32'h0000_0666, 4'hF, 3'b000);
    wait_accept();
    @(posedge ACLK); #1;
    check("early_bready", BVALID, 1'b0);
    BREADY = 1'b0;
    RREADY = 1'b1;
    start_read(8'd6, 3'b000);
    read_accept();
    @(posedge ACLK); #1;
    check("early_rready", RVALID, 1'b0);
    RREADY = 1'b0;

    // Same-edge write commit and read capture of one register.
    axi_write(8'd2, 32'h7, 4'hF, 3'b000, br);
    fork
      start_write(8'd2, 32'h55, 4'hF, 3'b000);
      start_read(8'd2, 3'b000);
    join
    fork
      wait_accept();
      read_accept();
    join
    fork
      complete_b(0, br);
      complete_r(0, rd, rr);
    join
    check("same_edge_old", rd, 32'h7);
    axi_read(8'd2, 3'b000, rd, rr);
    check("same_edge_new", rd, 32'h55);

    // Reset while a read response is pending.
    start_read(8'd1, 3'b000);
    read_accept();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    check("rst_mid_rvalid", RVALID, 1'b0);
    check_reset_outputs();
    axi_read(8'd0, 3'b000, rd, rr);
    check("post_rst_rdata", rd, 0);
    check("post_rst_rresp", rr, `RESP_OKAY);

    // Secure register 0 under non-secure and secure writes.
    axi_write(8'd0, 32'hC0DE0001, 4'hF, 3'b010, br);
    check("prot_ns_bresp", br, PROT_EN ? `RESP_SLVERR : `RESP_OKAY);
    check("prot_ns_reg", REGS_OUT[31:0], PROT_EN ? 32'h0 : 32'hC0DE0001);
    axi_write(8'd0, 32'hC0DE0002, 4'hF, 3'b000, br);
    check("prot_s_bresp", br, `RESP_OKAY);
    check("prot_s_reg", REGS_OUT[31:0], 32'hC0DE0002);

    repeat (3) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) holding a register file of DEPTH words; it is the other end of the team's AXI4-Lite master.
- Accepts word-indexed writes with byte strobes and serves reads.
- Returns OKAY/SLVERR on the B and R channels; response codes are the `RESP_* values from global.inc.
- Register contents are exported flat for downstream control logic.

Parameters:
- ADDR_WIDTH, 8, address bus width; addresses are word indices, not byte addresses.
- DATA_WIDTH, 32, data bus width; multiple of 8.
- DEPTH, 8, number of registers; power of 2, 2..2^ADDR_WIDTH; IDX_W = clog2(DEPTH).
- SECURE_MASK, {DEPTH{1'b0}}, bit i=1 marks register i secure-only; used only with the optional feature.

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous active-high reset
- AWADDR  in  ADDR_WIDTH  write address
- AWPROT  in  3  write protection
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte-lane strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_WIDTH  read address
- ARPROT  in  3  read protection
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- REGS_OUT  out  DEPTH*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (ARESET=1 at an ACLK edge):
  - all registers = 0;
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0;
  - BRESP, RRESP = `RESP_OKAY; RDATA = 0;
  - both FSMs go to IDLE.
  - Reset mid-transaction discards any pending response and any uncommitted write.
- All outputs are registered. The write FSM and read FSM are fully independent and run concurrently.
- Write FSM: W_IDLE -> W_ACK -> W_RESP -> W_IDLE.
  - W_IDLE: if AWVALID & WVALID are both sampled high, go to W_ACK and assert AWREADY and WREADY together for exactly one cycle. Address and data are never accepted separately, so a master waiting for AWREADY & WREADY in the same cycle cannot hang.
  - W_ACK: capture AWADDR/WDATA/WSTRB/AWPROT at this edge (both handshakes complete). Commit the write at the same edge: byte lane b is written only if WSTRB[b]=1. Drop both readys, set BVALID=1 with BRESP, go to W_RESP.
  - Decode: if AWADDR >= DEPTH, no register changes and BRESP = `RESP_SLVERR; otherwise BRESP = `RESP_OKAY.
  - W_RESP: hold BVALID/BRESP stable until BVALID & BREADY are sampled high, then BVALID=0 and go to W_IDLE. A new write is accepted no earlier than the cycle after BVALID falls.
  - Latency: valids seen at edge 0 -> readys high in cycle 1 -> BVALID high in cycle 2. Minimum 3 cycles per write.
- Read FSM: R_IDLE -> R_ACK -> R_DATA -> R_IDLE.
  - R_IDLE: if ARVALID is sampled high, assert ARREADY for one cycle and go to R_ACK.
  - R_ACK: capture ARADDR and load RDATA from the register file. Out of range (ARADDR >= DEPTH): RDATA=0, RRESP = `RESP_SLVERR; otherwise RRESP = `RESP_OKAY. Set RVALID=1, go to R_DATA.
  - R_DATA: hold RVALID/RDATA/RRESP stable until RVALID & RREADY, then RVALID=0 and go to R_IDLE.
- Simultaneous events:
  - A write commit and a read capture at the same edge to the same register: the read returns the pre-write value; the write still commits.
  - BREADY or RREADY may already be high before valid; the response completes in its first valid cycle.
- Address wrap: full ADDR_WIDTH compare; no aliasing. With DEPTH=8, ADDR 8 or 255 gets SLVERR, never register 0 or 7.
- REGS_OUT reflects a committed write from the cycle after the commit edge.

Optional Feature:
- Macro AXIL_REG_SLAVE_PROT_CHECK_EN.
- Defined: an access with AxPROT[1]=1 (non-secure) to an in-range index i where SECURE_MASK[i]=1 is rejected.
  - Write: no register change, BRESP = `RESP_SLVERR.
  - Read: RDATA=0, RRESP = `RESP_SLVERR.
  - Timing is identical to a normal access.
- Not defined: AWPROT/ARPROT and SECURE_MASK are ignored; only the range check produces SLVERR.

Test Plan:
- Reset then write ADDR=0..7 with WDATA=0x1F+i, WSTRB=4'hF, AWPROT=3'b010; read 0..7 -> each BRESP=OKAY, RDATA=0x1F+i, RRESP=OKAY; BVALID exactly 2 cycles after the valids rise.
- Reg 3 holds 0xAABBCCDD; write 0x11223344 with WSTRB=4'b0101 -> read gives 0xAA22CC44; REGS_OUT[127:96] matches.
- Write ADDR=8, then read ADDR=255 -> BRESP=SLVERR with REGS_OUT unchanged; RRESP=SLVERR, RDATA=0.
- Hold BREADY=0 for 5 cycles after BVALID; assert AWVALID/WVALID for a second write meanwhile -> BVALID and BRESP stable, AWREADY=WREADY=0 until one cycle after B completes.
- Same-edge write 0x55 and read of reg 2 (old value 0x7) -> RDATA=0x7; a later read returns 0x55.
- ARESET pulsed while RVALID=1 -> RVALID=0 next cycle; all REGS_OUT=0; a new read of reg 0 returns 0, OKAY.
- With AXIL_REG_SLAVE_PROT_CHECK_EN and SECURE_MASK=8'h01: write reg 0 with AWPROT=3'b010 -> SLVERR, reg unchanged; with AWPROT=3'b000 -> OKAY, reg updated.
